// File: rtl/regfile_wb_arbiter.sv
// Register-file scoreboard and writeback arbiter for the decode stage.
// - Tracks in-flight producers in a busy vector.
// - Stalls issue on RAW/WAW hazards.
// - Round-robin arbitrates the ALU (wb0) and load (wb1) writebacks onto the
//   single registered write port.
// Optional feature macro: REGFILE_WB_EARLY_RELEASE_EN. When defined, a
// register granted writeback this cycle is treated as free by the hazard
// checks.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_uses_rs1,
  input  logic            issue_uses_rs2,
  input  logic            issue_writes_rd,
  output logic            issue_ready,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  input  logic            flush,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            rr_last_q, rr_last_d;
  logic            rf_we_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;

  logic            grant0, grant1, gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic [NREG-1:0] hazard_busy;
  logic            issue_fire;

  // Round-robin grant: on contention, the requester that did not win last time wins.
  always_comb begin
    grant0   = wb0_valid && (!wb1_valid || rr_last_q);
    grant1   = wb1_valid && (!wb0_valid || !rr_last_q);
    gnt_any  = grant0 || grant1;
    gnt_rd   = grant1 ? wb1_rd : wb0_rd;
    gnt_data = grant1 ? wb1_data : wb0_data;
  end

  // Busy view used by the hazard checks.
  always_comb begin
    hazard_busy = busy_q;
`ifdef REGFILE_WB_EARLY_RELEASE_EN
    // The granted register is written next edge; decode forwards rf_wdata.
    if (gnt_any) hazard_busy[gnt_rd] = 1'b0;
`endif
  end

  // Issue is allowed only when no operand or destination is pending and not flushing.
  always_comb begin
    issue_ready = !flush
                  && !(issue_uses_rs1 && hazard_busy[issue_rs1])
                  && !(issue_uses_rs2 && hazard_busy[issue_rs2])
                  && !(issue_writes_rd && hazard_busy[issue_rd]);
    issue_fire  = issue_valid && issue_ready;
  end

  // Scoreboard next state: clear on writeback, set on issue (set wins), flush wins over all.
  always_comb begin
    busy_d = busy_q;
    if (gnt_any) busy_d[gnt_rd] = 1'b0;
    if (issue_fire && issue_writes_rd) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Arbiter history follows the granted index.
  always_comb begin
    rr_last_d = rr_last_q;
    if (grant1) begin
      rr_last_d = 1'b1;
    end else if (grant0) begin
      rr_last_d = 1'b0;
    end
  end

  // State and registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      rr_last_q  <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
      rf_we_q   <= gnt_any && (gnt_rd != '0);
      if (gnt_any) begin
        rf_waddr_q <= gnt_rd;
        rf_wdata_q <= gnt_data;
      end
    end
  end

  // Output mapping.
  always_comb begin
    wb0_ready = grant0;
    wb1_ready = grant1;
    rf_we     = rf_we_q;
    rf_waddr  = rf_waddr_q;
    rf_wdata  = rf_wdata_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a behavioural model predicts each
// cycle's combinational handshakes and the registered state after the edge;
// a negedge monitor pops and compares those expectations.
module tb_regfile_wb_arbiter;

  logic        clk, reset;
  logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready, flush, rf_we;
  logic [4:0]  wb0_rd, wb1_rd, rf_waddr;
  logic [31:0] wb0_data, wb1_data, rf_wdata, busy;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_writes_rd(issue_writes_rd), .issue_ready(issue_ready),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {int due; bit ir; bit g0; bit g1;} comb_t;
  typedef struct {int due; bit we; logic [4:0] a; logic [31:0] d; logic [31:0] b;} reg_t;
  comb_t cq[$];
  reg_t  rq[$];

  // Reference model state: set of pending registers, last winner, held write port.
  bit          mb[32];
  int          last_win;
  logic [4:0]  ma;
  logic [31:0] md;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every expectation whose edge has arrived.
  comb_t cm;
  reg_t  rm;
  always @(negedge clk) begin
    while (cq.size() > 0 && cq[0].due <= edge_cnt) begin
      cm = cq.pop_front();
      chk("issue_ready", {31'b0, issue_ready}, {31'b0, cm.ir});
      chk("wb0_ready", {31'b0, wb0_ready}, {31'b0, cm.g0});
      chk("wb1_ready", {31'b0, wb1_ready}, {31'b0, cm.g1});
    end
    while (rq.size() > 0 && rq[0].due <= edge_cnt) begin
      rm = rq.pop_front();
      chk("rf_we", {31'b0, rf_we}, {31'b0, rm.we});
      chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, rm.a});
      chk("rf_wdata", rf_wdata, rm.d);
      chk("busy", busy, rm.b);
    end
  end

  function automatic void model_reset();
    foreach (mb[i]) mb[i] = 1'b0;
    last_win = 1;
    ma = '0;
    md = '0;
  endfunction

  function automatic bit pending(input logic [4:0] r, input bit gv, input logic [4:0] grd);
    if (r == 0) return 1'b0;
`ifdef REGFILE_WB_EARLY_RELEASE_EN
    if (gv && r == grd) return 1'b0;
`endif
    return mb[r];
  endfunction

  // One clock cycle: drive inputs, predict handshakes and post-edge state.
  task automatic step(input bit iv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input bit u1, input bit u2, input bit w,
                      input bit v0, input logic [4:0] d0, input logic [31:0] x0,
                      input bit v1, input logic [4:0] d1, input logic [31:0] x1,
                      input bit fl, output bit g0, output bit g1);
    int win;
    bit gv, ir;
    logic [4:0] grd;
    logic [31:0] gdat, bv;
    reg_t e;
    comb_t c;
    @(posedge clk);
    #1;
    issue_valid = iv; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd;
    issue_uses_rs1 = u1; issue_uses_rs2 = u2; issue_writes_rd = w;
    wb0_valid = v0; wb0_rd = d0; wb0_data = x0;
    wb1_valid = v1; wb1_rd = d1; wb1_data = x1;
    flush = fl;
    #1;
    if (v0 && v1) win = (last_win == 0) ? 1 : 0;
    else if (v0) win = 0;
    else if (v1) win = 1;
    else win = -1;
    gv   = (win >= 0);
    g0   = (win == 0);
    g1   = (win == 1);
    grd  = g1 ? d1 : d0;
    gdat = g1 ? x1 : x0;
    ir = !fl && !(u1 && pending(r1, gv, grd)) && !(u2 && pending(r2, gv, grd))
         && !(w && pending(rd, gv, grd));
    c.due = edge_cnt; c.ir = ir; c.g0 = g0; c.g1 = g1;
    cq.push_back(c);
    e.we = 1'b0;
    if (gv) begin
      if (grd != 0) mb[grd] = 1'b0;
      e.we = (grd != 0);
      ma = grd;
      md = gdat;
      last_win = win;
    end
    if (iv && ir && w && rd != 0) mb[rd] = 1'b1;
    if (fl) foreach (mb[i]) mb[i] = 1'b0;
    bv = '0;
    foreach (mb[i]) bv[i] = mb[i];
    e.due = edge_cnt + 1; e.a = ma; e.d = md; e.b = bv;
    rq.push_back(e);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    flush = 0;
  endtask

  // Assert reset asynchronously mid-cycle and check outputs drop at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    #1;
    cq.delete();
    rq.delete();
    chk("rst_busy", busy, 32'h0);
    chk("rst_rf_we", {31'b0, rf_we}, 32'h0);
    chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'h0);
    chk("rst_rf_wdata", rf_wdata, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  bit g0, g1, p0, p1;
  logic [4:0] q0, q1;
  logic [31:0] y0, y1;

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    do_reset();
    // Any operands issue after reset.
    step(1, 5'd4, 5'd9, 5'd17, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    // RAW on x5, then ALU writeback releases it.
    step(1, 0, 0, 5'd5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 5'd5, 0, 5'd6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 5'd5, 0, 5'd6, 1, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, g0, g1);
    step(1, 5'd5, 0, 5'd6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    // Contention from reset: wb0, wb1, wb0.
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, g0, g1);
    // x0 producer and writeback.
    step(1, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h1234, 0, g0, g1);
    // Flush with a granted writeback.
    step(1, 0, 0, 5'd3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 0, 0, 5'd7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 5'd1, 0, 5'd8, 1, 0, 1, 1, 5'd3, 32'hCAFE0003, 0, 0, 0, 1, g0, g1);
    // Writeback and dependent issue in the same cycle.
    step(1, 0, 0, 5'd9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 5'd9, 0, 5'd9, 1, 0, 1, 1, 5'd9, 32'h99, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // Randomised traffic; requesters hold their request until granted.
    p0 = 0; p1 = 0; q0 = 0; q1 = 0; y0 = 0; y1 = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset();
        p0 = 0;
        p1 = 0;
      end
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; q0 = 5'($urandom_range(0, 7)); y0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; q1 = 5'($urandom_range(0, 7)); y1 = $urandom;
      end
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), p0, q0, y0, p1, q1, y1,
           ($urandom_range(0, 19) == 0), g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
